sd_card_cmd_responder: RTL and testbench

- Card-side model/endpoint of the SD CMD line, sitting directly downstream of the host's CMD pin.
- Deserialises 48-bit host command frames and checks them (framing + CRC7).
- Presents the decoded index/argument to card logic, then serialises a 48-bit R1-format response back on the line after NCR idle cycles.
- Used as the bench/FPGA card counterpart for the host command path.

---
 rtl/sd_card_cmd_responder.sv | 148 ++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks framing/CRC7 and answers
// with an R1-format response after NCR cycles. Define SD_CARD_CMD_CRC_CHECK_EN to check received CRC.
module sd_card_cmd_responder #(
   parameter int unsigned NCR           = 2,
   parameter int unsigned NO_RESP_INDEX = 0
) (
   input  logic        sd_clock,
   input  logic        reset,
   input  logic        cmd_in,
   output logic        cmd_out,
   output logic        cmd_oe,
   input  logic [31:0] card_status,
   input  logic        resp_en,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg_o,
   output logic        frame_error,
   output logic        busy
);

   typedef enum logic [2:0] {StIdle, StRecv, StCheck, StWaitNcr, StSend} state_e;

   state_e      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [46:0] shift_q, shift_d;
   logic [6:0]  crc_q, crc_d;
   logic        frame_ok_q, frame_ok_d;
   logic [5:0]  index_q, index_d;
   logic [31:0] arg_q, arg_d;
   logic [47:0] resp_q, resp_d;
   logic [47:0] frame;
   logic        frame_ok;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   // Full frame as seen while the end bit is on the line (last RECV cycle).
   assign frame = {shift_q, cmd_in};

`ifdef SD_CARD_CMD_CRC_CHECK_EN
   assign frame_ok = !frame[47] && frame[46] && frame[0] && (frame[7:1] == crc_q);
`else
   logic unused_crc;
   assign unused_crc = ^{crc_q, frame[7:1]};
   assign frame_ok   = !frame[47] && frame[46] && frame[0];
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      crc_d       = crc_q;
      frame_ok_d  = frame_ok_q;
      index_d     = index_q;
      arg_d       = arg_q;
      resp_d      = resp_q;
      cmd_out     = 1'b1;
      cmd_oe      = 1'b0;
      cmd_valid   = 1'b0;
      frame_error = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!cmd_in) begin
               state_d = StRecv;
               cnt_d   = 7'd1;
               shift_d = '0;
               crc_d   = '0;
            end
         end
         StRecv: begin
            shift_d = {shift_q[45:0], cmd_in};
            if (cnt_q <= 7'd39) crc_d = crc7_step(crc_q, cmd_in);
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd47) begin
               state_d    = StCheck;
               frame_ok_d = frame_ok;
               if (frame_ok) begin
                  index_d = frame[45:40];
                  arg_d   = frame[39:8];
               end
            end
         end
         StCheck: begin
            cmd_valid   = frame_ok_q;
            frame_error = !frame_ok_q;
            // CHECK is the first of the NCR idle cycles.
            cnt_d       = 7'd2;
            if (frame_ok_q && resp_en && (index_q != NO_RESP_INDEX[5:0])) state_d = StWaitNcr;
            else state_d = StIdle;
         end
         StWaitNcr: begin
            if (cnt_q >= NCR[6:0]) begin
               resp_d  = {2'b00, index_q, card_status,
                          crc7_40({2'b00, index_q, card_status}), 1'b1};
               cnt_d   = '0;
               state_d = StSend;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         StSend: begin
            cmd_oe  = 1'b1;
            cmd_out = resp_q[47];
            resp_d  = {resp_q[46:0], 1'b1};
            cnt_d   = cnt_q + 7'd1;
            if (cnt_q == 7'd47) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         crc_q      <= '0;
         frame_ok_q <= 1'b0;
         index_q    <= '0;
         arg_q      <= '0;
         resp_q     <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         crc_q      <= crc_d;
         frame_ok_q <= frame_ok_d;
         index_q    <= index_d;
         arg_q      <= arg_d;
         resp_q     <= resp_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign cmd_index_o = index_q;
   assign cmd_arg_o   = arg_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: command decode, R1 response timing/content,
// error frames, no-response cases and mid-frame reset.
module tb_sd_card_cmd_responder;

   logic        sd_clock = 1'b0;
   logic        reset, cmd_in, cmd_out, cmd_oe, resp_en, cmd_valid, frame_error, busy;
   logic [31:0] card_status, cmd_arg_o;
   logic [5:0]  cmd_index_o;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [5:0]  exp_idx;

   always #5 sd_clock = ~sd_clock;

   sd_card_cmd_responder dut (
      .sd_clock    (sd_clock),
      .reset       (reset),
      .cmd_in      (cmd_in),
      .cmd_out     (cmd_out),
      .cmd_oe      (cmd_oe),
      .card_status (card_status),
      .resp_en     (resp_en),
      .cmd_valid   (cmd_valid),
      .cmd_index_o (cmd_index_o),
      .cmd_arg_o   (cmd_arg_o),
      .frame_error (frame_error),
      .busy        (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // CRC7 by polynomial long division (x^7+x^3+1 = 8'h89).
   function automatic logic [6:0] crc7_div(input logic [39:0] d);
      logic [46:0] r;
      r = {d, 7'b0};
      for (int i = 46; i >= 7; i--) begin
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] st);
      return {2'b00, idx, st, crc7_div({2'b00, idx, st}), 1'b1};
   endfunction

   // Drives all 48 bits; returns at the negedge of the cycle after the end bit was sampled.
   task automatic send_frame(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         @(posedge sd_clock);
         #1 cmd_in = f[i];
      end
      @(posedge sd_clock);
      #1 cmd_in = 1'b1;
      @(negedge sd_clock);
   endtask

   task automatic expect_resp(input string tag, input logic [47:0] exp_frame);
      logic [47:0] r = '0;
      logic oe_all = 1'b1;
      @(negedge sd_clock);
      check_eq({tag, "_ncr_wait"}, {cmd_oe, cmd_valid, busy}, 3'b001);
      repeat (48) begin
         @(negedge sd_clock);
         oe_all &= cmd_oe;
         r = {r[46:0], cmd_out};
      end
      check_eq({tag, "_oe48"}, oe_all, 1'b1);
      check_eq({tag, "_frame"}, r, exp_frame);
      @(negedge sd_clock);
      check_eq({tag, "_after"}, {cmd_oe, cmd_out, busy}, 3'b010);
   endtask

   task automatic expect_silent(input string tag, input int cycles);
      logic any_oe = 1'b0;
      repeat (cycles) begin
         @(negedge sd_clock);
         any_oe |= cmd_oe;
      end
      check_eq(tag, {any_oe, busy}, 2'b00);
   endtask

   initial begin
      reset       = 1'b1;
      cmd_in      = 1'b1;
      resp_en     = 1'b1;
      card_status = 32'h0000_0120;
      repeat (2) @(posedge sd_clock);
      @(negedge sd_clock);
      check_eq("reset_ctrl", {cmd_out, cmd_oe, cmd_valid, frame_error, busy}, 5'b10000);
      check_eq("reset_idx", cmd_index_o, 6'd0);
      check_eq("reset_arg", cmd_arg_o, 32'd0);
      @(posedge sd_clock);
      #1 reset = 1'b0;
      @(negedge sd_clock);
      check_eq("idle_busy", {busy, cmd_oe}, 2'b00);

      // CMD8 with response
      send_frame(48'h48_000001AA_87);
      check_eq("cmd8_pulse", {cmd_valid, frame_error}, 2'b10);
      check_eq("cmd8_idx", cmd_index_o, 6'd8);
      check_eq("cmd8_arg", cmd_arg_o, 32'h0000_01AA);
      expect_resp("cmd8", resp_frame(6'd8, 32'h0000_0120));

      // CMD0 never answered
      send_frame(48'h40_00000000_95);
      check_eq("cmd0_pulse", {cmd_valid, frame_error}, 2'b10);
      check_eq("cmd0_idx", cmd_index_o, 6'd0);
      expect_silent("cmd0_silent", 60);

      // CMD55 with responses disabled
      resp_en = 1'b0;
      send_frame(48'h77_00000000_65);
      check_eq("cmd55_pulse", {cmd_valid, frame_error}, 2'b10);
      check_eq("cmd55_idx", cmd_index_o, 6'd55);
      @(negedge sd_clock);
      check_eq("cmd55_idle", {busy, cmd_oe, cmd_valid}, 3'b000);
      resp_en = 1'b1;

      // CMD17 with corrupted CRC
      card_status = 32'h0000_0900;
      send_frame(48'h51_00000000_57);
`ifdef SD_CARD_CMD_CRC_CHECK_EN
      check_eq("cmd17_pulse", {cmd_valid, frame_error}, 2'b01);
      check_eq("cmd17_idx_kept", cmd_index_o, 6'd55);
      expect_silent("cmd17_silent", 60);
      exp_idx = 6'd55;
`else
      check_eq("cmd17_pulse", {cmd_valid, frame_error}, 2'b10);
      check_eq("cmd17_idx", cmd_index_o, 6'd17);
      expect_resp("cmd17", resp_frame(6'd17, 32'h0000_0900));
      exp_idx = 6'd17;
`endif

      // Bad end bit
      send_frame(48'h48_000001AA_86);
      check_eq("badend_pulse", {cmd_valid, frame_error}, 2'b01);
      check_eq("badend_idx_kept", cmd_index_o, exp_idx);
      expect_silent("badend_silent", 60);

      // Reset in the middle of a CMD8 frame
      for (int i = 47; i >= 28; i--) begin
         @(posedge sd_clock);
         #1 cmd_in = 1'b0 ^ (48'h48_000001AA_87 >> i);
      end
      @(posedge sd_clock);
      #1 reset = 1'b1;
      cmd_in = 1'b1;
      @(posedge sd_clock);
      #1 reset = 1'b0;
      @(negedge sd_clock);
      check_eq("midrst_idle", {busy, cmd_oe, cmd_valid}, 3'b000);
      check_eq("midrst_idx", cmd_index_o, 6'd0);
      send_frame(48'h77_00000000_65);
      check_eq("post_rst_pulse", {cmd_valid, frame_error}, 2'b10);
      check_eq("post_rst_idx", cmd_index_o, 6'd55);
      expect_resp("post_rst", resp_frame(6'd55, 32'h0000_0900));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
